interrupt_unit: RTL

Upstream interrupt/reset sequencer for the MSP430 control path. It produces the `rst` and `INTREQ` qualifiers consumed by the CAR next-address logic and the vector address read by the INT0/INT4 microsequences. It also emits one-hot acknowledge pulses so peripherals can clear single-source flags. It stretches and synchronizes external reset, edge-detects NMI, prioritizes maskable requests under GIE, and holds a request until the control unit acknowledges it.

---
 rtl/interrupt_unit_pkg.sv | 23 ++
 rtl/interrupt_unit_sync2.sv | 22 ++
 rtl/interrupt_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/interrupt_unit_pkg.sv
// Shared constants for the interrupt/reset sequencer: vector map, priority
// index width and the sequencer state type.
package interrupt_unit_pkg;

    localparam logic [15:0] VEC_RESET    = 16'hFFFE;
    localparam logic [15:0] VEC_NMI      = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_BASE = 16'hFFE0;

    // Wide enough to index up to 16 maskable sources.
    localparam int PRIO_W = 4;

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_PEND,
        S_ACK
    } iu_state_e;

    function automatic logic [15:0] irq_vector(input logic [PRIO_W-1:0] idx);
        return VEC_IRQ_BASE + {11'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/interrupt_unit_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear; used for the NMI
// pin and for the release edge of the external reset.
module interrupt_unit_sync2 (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt/reset sequencer: stretches reset, edge-detects NMI, prioritizes
// maskable requests under GIE and holds a request until the control unit acks.
module interrupt_unit
    import interrupt_unit_pkg::*;
#(
    parameter int NUM_IRQ  = 14,
    parameter int RST_HOLD = 4,
    parameter int ADDR_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               NMI,
    input  logic               NMIIE,
    input  logic               GIE,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               INTACK,
    output logic               rst,
    output logic               INTREQ,
    output logic [ADDR_W-1:0]  VEC,
    output logic [NUM_IRQ-1:0] IRQACC,
    output logic               NMIACC
);

    localparam int CNT_W = $clog2(RST_HOLD + 1);

    iu_state_e          state;
    logic [CNT_W-1:0]   hold_cnt;
    logic               rst_sync;
    logic               nmi_sync;
    logic               nmi_prev;
    logic               nmi_pend;
    logic [NUM_IRQ-1:0] irq_q;

    logic               nmi_rise;
    logic               nmi_qual;
    logic               irq_any;
    logic               any_qual;
    logic               nmi_grant;
    logic [PRIO_W-1:0]  win_idx;
    logic [ADDR_W-1:0]  win_vec;
    logic [NUM_IRQ-1:0] irq_onehot;

    interrupt_unit_sync2 u_rst_sync (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync)
    );

    interrupt_unit_sync2 u_nmi_sync (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (NMI),
        .q     (nmi_sync)
    );

    // Highest set index wins; later iterations overwrite earlier ones.
    function automatic logic [PRIO_W-1:0] top_index(input logic [NUM_IRQ-1:0] req);
        logic [PRIO_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) idx = PRIO_W'(i);
        end
        return idx;
    endfunction

    assign nmi_rise  = nmi_sync & ~nmi_prev;
    assign nmi_qual  = nmi_pend & NMIIE;
    assign irq_any   = |irq_q;
    assign any_qual  = nmi_qual | irq_any;
    assign win_idx   = top_index(irq_q);
    assign win_vec   = nmi_qual ? ADDR_W'(VEC_NMI) : ADDR_W'(irq_vector(win_idx));
    assign nmi_grant = (state == S_PEND) & INTACK & nmi_qual;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
        assign irq_onehot[gi] = irq_any & ~nmi_qual & (win_idx == PRIO_W'(gi));
    end

    // Qualifier registers: GIE gating adds one cycle, NMI is held until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
            irq_q    <= '0;
        end else begin
            nmi_prev <= nmi_sync;
            irq_q    <= IRQ & {NUM_IRQ{GIE}};
            if (nmi_rise)
                nmi_pend <= 1'b1;
            else if (nmi_grant)
                nmi_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            hold_cnt <= '0;
            rst      <= 1'b1;
            INTREQ   <= 1'b0;
            VEC      <= ADDR_W'(VEC_RESET);
            IRQACC   <= '0;
            NMIACC   <= 1'b0;
        end else begin
            IRQACC <= '0;
            NMIACC <= 1'b0;
            case (state)
                S_RESET: begin
                    if (rst_sync) begin
                        if (hold_cnt == CNT_W'(RST_HOLD)) begin
                            state <= S_IDLE;
                            rst   <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (any_qual) begin
                        state  <= S_PEND;
                        INTREQ <= 1'b1;
                        VEC    <= win_vec;
                    end
                end
                S_PEND: begin
                    if (!any_qual) begin
                        state  <= S_IDLE;
                        INTREQ <= 1'b0;
                    end else if (INTACK) begin
                        state  <= S_ACK;
                        INTREQ <= 1'b0;
                        VEC    <= win_vec;
                        IRQACC <= irq_onehot;
                        NMIACC <= nmi_qual;
                    end else begin
                        VEC <= win_vec;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule
